multi_channel_dimmer: RTL and testbench

Multi-channel successor to the single-channel contrast box: NUM_CHANNELS independent gamma-corrected PWM outputs driven by linear per-channel levels. Levels are set from up/down/select buttons with hold-to-repeat, or by an automatic ramp or triangle sweep. PWM duty updates are glitch-free and take effect only at PWM period boundaries. Sits between the debounced front-panel buttons and the LED/backlight drivers.

---
 rtl/multi_channel_dimmer_pkg.sv | 22 ++
 rtl/dimmer_gamma_lut.sv | 24 ++
 rtl/multi_channel_dimmer.sv | 182 ++++++++++++++++++
 tb/tb_multi_channel_dimmer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_dimmer_pkg.sv
// Shared mode encodings and saturating arithmetic for the multi-channel dimmer.
package multi_channel_dimmer_pkg;

    localparam logic [1:0] MODE_MANUAL   = 2'b00;
    localparam logic [1:0] MODE_RAMP     = 2'b01;
    localparam logic [1:0] MODE_TRIANGLE = 2'b10;
    localparam logic [1:0] MODE_FREEZE   = 2'b11;

    // a + b, clamped to max_v
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
    endfunction

    // a - b, clamped to 0
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/dimmer_gamma_lut.sv
// Combinational gamma correction: duty = level^EXPONENT scaled back to PWM_WIDTH bits.
module dimmer_gamma_lut #(
    parameter int unsigned PWM_WIDTH = 10,
    parameter int unsigned EXPONENT  = 3
) (
    input  logic [PWM_WIDTH-1:0] level,
    output logic [PWM_WIDTH-1:0] duty
);

    localparam int unsigned PROD_W = PWM_WIDTH * EXPONENT;
    localparam int unsigned SHIFT  = PWM_WIDTH * (EXPONENT - 1);

    logic [PROD_W-1:0] prod;

    // Repeated multiply, then drop the extra fractional bits
    always_comb begin
        prod = PROD_W'(level);
        for (int i = 1; i < int'(EXPONENT); i++) begin
            prod = prod * PROD_W'(level);
        end
        duty = PWM_WIDTH'(prod >> SHIFT);
    end

endmodule

// File: rtl/multi_channel_dimmer.sv
// Multi-channel gamma-corrected PWM dimmer with button and automatic level control.
module multi_channel_dimmer
    import multi_channel_dimmer_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned PWM_WIDTH     = 10,
    parameter int unsigned PWM_PRESCALE  = 16,
    parameter int unsigned STEP_VALUE    = 11,
    parameter int unsigned REPEAT_CYCLES = 800000,
    parameter int unsigned AUTO_CYCLES   = 1600000,
    parameter int unsigned EXPONENT      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_sel,
    input  logic [1:0]              mode,
    output logic [NUM_CHANNELS-1:0] pwm_out,
    output logic [(NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1)-1:0] sel_channel,
    output logic [PWM_WIDTH-1:0]    level_out,
    output logic                    level_changed
);

    localparam int unsigned SEL_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned REP_W  = $clog2(REPEAT_CYCLES + 1);
    localparam int unsigned AUTO_W = $clog2(AUTO_CYCLES + 1);
    localparam int unsigned PRE_W  = $clog2(PWM_PRESCALE + 1);
    localparam logic [PWM_WIDTH-1:0] LVL_MAX = {PWM_WIDTH{1'b1}};

    logic [PWM_WIDTH-1:0]    level        [NUM_CHANNELS];
    logic [PWM_WIDTH-1:0]    level_nxt    [NUM_CHANNELS];
    logic [PWM_WIDTH-1:0]    pending_duty [NUM_CHANNELS];
    logic [PWM_WIDTH-1:0]    active_duty  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] dir_down, dir_down_nxt;

    logic              up_q, down_q, sel_q;
    logic [REP_W-1:0]  rep_cnt, rep_cnt_nxt;
    logic [AUTO_W-1:0] auto_cnt;
    logic [PRE_W-1:0]  presc_cnt;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [SEL_W-1:0]  scan_idx, sel_nxt;

    logic up_rise, down_rise, sel_rise, both, rep_hit;
    logic step_up, step_down, auto_on, auto_tick, frozen, any_change;
    logic presc_tick, pwm_wrap;
    logic [PWM_WIDTH-1:0] gamma_level, gamma_duty;

    // Gamma LUT shared by the rotating scan engine
    dimmer_gamma_lut #(
        .PWM_WIDTH(PWM_WIDTH),
        .EXPONENT (EXPONENT)
    ) u_gamma (
        .level(gamma_level),
        .duty (gamma_duty)
    );

    assign gamma_level = level[scan_idx];

    // Button edges, repeat timing, auto tick and next level/direction per channel
    always_comb begin
        up_rise    = btn_up & ~up_q;
        down_rise  = btn_down & ~down_q;
        sel_rise   = btn_sel & ~sel_q;
        both       = btn_up & btn_down;
        rep_hit    = (rep_cnt == REP_W'(REPEAT_CYCLES - 1));
        step_up    = !both && btn_up && (up_rise || rep_hit);
        step_down  = !both && btn_down && (down_rise || rep_hit);
        auto_on    = (mode == MODE_RAMP) || (mode == MODE_TRIANGLE);
        auto_tick  = auto_on && (auto_cnt == AUTO_W'(AUTO_CYCLES - 1));
        frozen     = (mode == MODE_FREEZE);
        any_change = 1'b0;
        dir_down_nxt = dir_down;

        if (both || (!btn_up && !btn_down) || sel_rise || up_rise || down_rise || rep_hit) begin
            rep_cnt_nxt = '0;
        end else begin
            rep_cnt_nxt = rep_cnt + REP_W'(1);
        end

        if (sel_rise) begin
            sel_nxt = (sel_channel == SEL_W'(NUM_CHANNELS - 1)) ? '0 : sel_channel + SEL_W'(1);
        end else begin
            sel_nxt = sel_channel;
        end

        for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
            level_nxt[k] = level[k];
            if (auto_tick) begin
                if (mode == MODE_RAMP || !dir_down[k]) begin
                    level_nxt[k] = PWM_WIDTH'(sat_add(32'(level[k]), STEP_VALUE, 32'(LVL_MAX)));
                    if (mode == MODE_TRIANGLE && level_nxt[k] == LVL_MAX) begin
                        dir_down_nxt[k] = 1'b1;
                    end
                end else begin
                    level_nxt[k] = PWM_WIDTH'(sat_sub(32'(level[k]), STEP_VALUE));
                    if (level_nxt[k] == '0) begin
                        dir_down_nxt[k] = 1'b0;
                    end
                end
            end
            // The button overrides the auto step on the selected channel
            if ((step_up || step_down) && (SEL_W'(k) == sel_channel)) begin
                dir_down_nxt[k] = dir_down[k];
                if (step_up) begin
                    level_nxt[k] = PWM_WIDTH'(sat_add(32'(level[k]), STEP_VALUE, 32'(LVL_MAX)));
                end else begin
                    level_nxt[k] = PWM_WIDTH'(sat_sub(32'(level[k]), STEP_VALUE));
                end
            end
            if (frozen) begin
                level_nxt[k]    = level[k];
                dir_down_nxt[k] = dir_down[k];
            end
            if (level_nxt[k] != level[k]) begin
                any_change = 1'b1;
            end
        end
    end

    // Level, selection and control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
                level[k] <= '0;
            end
            dir_down      <= '0;
            up_q          <= 1'b0;
            down_q        <= 1'b0;
            sel_q         <= 1'b0;
            rep_cnt       <= '0;
            auto_cnt      <= '0;
            sel_channel   <= '0;
            level_out     <= '0;
            level_changed <= 1'b0;
        end else begin
            for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
                level[k] <= level_nxt[k];
            end
            dir_down      <= dir_down_nxt;
            up_q          <= btn_up;
            down_q        <= btn_down;
            sel_q         <= btn_sel;
            rep_cnt       <= rep_cnt_nxt;
            auto_cnt      <= (!auto_on || auto_tick) ? '0 : auto_cnt + AUTO_W'(1);
            sel_channel   <= sel_nxt;
            level_out     <= level_nxt[sel_nxt];
            level_changed <= any_change;
        end
    end

    assign presc_tick = (presc_cnt == PRE_W'(PWM_PRESCALE - 1));
    assign pwm_wrap   = presc_tick && (pwm_cnt == LVL_MAX);

    // Duty scan, PWM counter and period-aligned duty transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
                pending_duty[k] <= '0;
                active_duty[k]  <= '0;
            end
            scan_idx  <= '0;
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            pwm_out   <= '0;
        end else begin
            pending_duty[scan_idx] <= gamma_duty;
            scan_idx  <= (scan_idx == SEL_W'(NUM_CHANNELS - 1)) ? '0 : scan_idx + SEL_W'(1);
            presc_cnt <= presc_tick ? '0 : presc_cnt + PRE_W'(1);
            if (presc_tick) begin
                pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
            end
            for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
                if (pwm_wrap) begin
                    active_duty[k] <= pending_duty[k];
                end
                pwm_out[k] <= (pwm_cnt < active_duty[k]);
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_dimmer.sv
// Self-checking bench for multi_channel_dimmer: vector table plus multi-cycle sequences.
module tb_multi_channel_dimmer;

    localparam int unsigned NCH    = 4;
    localparam int unsigned PW     = 10;
    localparam int unsigned PRE    = 4;
    localparam int unsigned PERIOD = PRE * (1 << PW);

    typedef struct {
        logic       up;
        logic       down;
        logic       sel;
        logic [1:0] mode;
        int         exp_level;
        int         exp_sel;
        int         exp_chg;
    } vec_t;

    logic clk = 1'b0;
    logic reset, btn_up, btn_down, btn_sel;
    logic [1:0] mode, mode2;
    logic zero_b;
    logic [NCH-1:0] pwm, pwm2;
    logic [1:0] sel, sel2;
    logic [PW-1:0] lvl, lvl2;
    logic chg, chg2;

    int checks = 0;
    int failures = 0;

    vec_t vecs[19];
    vec_t exp_q[$];
    int   int_q[$];

    always #5 clk = ~clk;

    multi_channel_dimmer #(
        .NUM_CHANNELS(NCH), .PWM_WIDTH(PW), .PWM_PRESCALE(PRE), .STEP_VALUE(11),
        .REPEAT_CYCLES(100), .AUTO_CYCLES(10), .EXPONENT(3)
    ) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .mode(mode), .pwm_out(pwm), .sel_channel(sel), .level_out(lvl), .level_changed(chg)
    );

    multi_channel_dimmer #(
        .NUM_CHANNELS(NCH), .PWM_WIDTH(PW), .PWM_PRESCALE(PRE), .STEP_VALUE(512),
        .REPEAT_CYCLES(100), .AUTO_CYCLES(10), .EXPONENT(3)
    ) dut_tri (
        .clk(clk), .reset(reset), .btn_up(zero_b), .btn_down(zero_b), .btn_sel(zero_b),
        .mode(mode2), .pwm_out(pwm2), .sel_channel(sel2), .level_out(lvl2), .level_changed(chg2)
    );

    function automatic int gamma_model(input int level);
        longint cube;
        cube = longint'(level) * longint'(level) * longint'(level);
        return int'(cube >> (PW * 2));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_sel();
        btn_sel = 1'b1;
        step();
        btn_sel = 1'b0;
        step();
    endtask

    // Count high samples of one pwm bit of the chosen DUT over n cycles
    task automatic count_high(input bit second, input int ch, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (second ? pwm2[ch] : pwm[ch]) cnt++;
        end
    endtask

    initial begin
        int cnt, cnt2, pulses, k;
        bit found, prev;
        vec_t v;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 11, 0, 1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 11, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 11, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd0,  0, 0, 1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd0,  0, 0, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'd0,  0, 0, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd0,  0, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd0,  0, 1, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 11, 1, 1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd0,  0, 2, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd0,  0, 2, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd0,  0, 3, 0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 2'd0,  0, 3, 0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 2'd0,  0, 0, 0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 2'd0,  0, 0, 0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 2'd0,  0, 0, 0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 2'd3,  0, 0, 0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 2'd3, 11, 1, 0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 2'd0, 11, 1, 0};

        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
        mode = 2'd0; mode2 = 2'd0; zero_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_level", int'(lvl), 0);
        check("reset_sel", int'(sel), 0);
        check("reset_pwm", int'(pwm), 0);
        check("reset_chg", int'(chg), 0);
        reset = 1'b0;
        step();

        // Table-driven manual-mode vectors, one cycle each
        for (int i = 0; i < 19; i++) begin
            btn_up = vecs[i].up; btn_down = vecs[i].down;
            btn_sel = vecs[i].sel; mode = vecs[i].mode;
            exp_q.push_back(vecs[i]);
            step();
            v = exp_q.pop_front();
            check($sformatf("vec%0d_level", i), int'(lvl), v.exp_level);
            check($sformatf("vec%0d_sel", i), int'(sel), v.exp_sel);
            check($sformatf("vec%0d_chg", i), int'(chg), v.exp_chg);
        end

        // Back to channel 0
        press_sel(); check("sel_wrap_2", int'(sel), 2);
        press_sel(); check("sel_wrap_3", int'(sel), 3);
        press_sel(); check("sel_wrap_0", int'(sel), 0);

        // Hold-to-repeat: steps at +0, +100, +200
        int_q = {0, 100, 200};
        btn_up = 1'b1;
        for (int i = 0; i <= 250; i++) begin
            step();
            if (chg) begin
                if (int_q.size() == 0) check("repeat_extra_pulse", i, -1);
                else begin
                    k = int_q.pop_front();
                    check("repeat_offset", i, k);
                end
            end
        end
        check("repeat_missing", int_q.size(), 0);
        check("repeat_level", int'(lvl), 33);
        pulses = 0;
        for (int i = 0; i < 9300; i++) begin
            step();
            if (chg) pulses++;
        end
        btn_up = 1'b0;
        check("sat_pulses", pulses, 90);
        check("sat_level", int'(lvl), 1023);

        // Saturated channel 0 duty over one full period; channel 1 (level 11) stays dark
        repeat (2 * PERIOD) step();
        count_high(1'b0, 0, PERIOD, cnt);
        check("pwm_full_duty", cnt, gamma_model(1023) * PRE);
        count_high(1'b0, 1, PERIOD, cnt);
        check("pwm_low_duty", cnt, gamma_model(11) * PRE);

        // Mid-period change: old duty holds until the wrap
        found = 1'b0;
        for (int i = 0; i < int'(PERIOD) + 16 && !found; i++) begin
            prev = pwm[0];
            step();
            if (!prev && pwm[0]) found = 1'b1;
        end
        check("period_start_found", int'(found), 1);
        cnt = 1;
        for (int i = 1; i < int'(PERIOD); i++) begin
            if (i == 2000) btn_down = 1'b1;
            if (i == 2001) btn_down = 1'b0;
            step();
            if (pwm[0]) cnt++;
        end
        count_high(1'b0, 0, PERIOD, cnt2);
        check("midperiod_old_duty", cnt, gamma_model(1023) * PRE);
        check("midperiod_new_duty", cnt2, gamma_model(1012) * PRE);
        check("midperiod_level", int'(lvl), 1012);

        // Button and auto tick together: selected channel takes only the button step
        press_sel();
        check("collide_sel", int'(sel), 1);
        mode = 2'd1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (chg) found = 1'b1;
        end
        check("ramp_tick_found", int'(found), 1);
        check("ramp_tick_level", int'(lvl), 22);
        repeat (9) step();
        btn_down = 1'b1;
        step();
        check("collide_level", int'(lvl), 11);
        check("collide_chg", int'(chg), 1);
        btn_down = 1'b0; mode = 2'd0;
        step();
        press_sel(); check("collide_ch2", int'(lvl), 22);
        press_sel(); check("collide_ch3", int'(lvl), 22);
        press_sel(); check("collide_ch0", int'(lvl), 1023);

        // Triangle sweep on the STEP=512 instance
        int_q = {512, 1023, 511, 0, 512};
        mode2 = 2'd2;
        for (int i = 0; i < 200 && int_q.size() != 0; i++) begin
            step();
            if (chg2) begin
                k = int_q.pop_front();
                check("tri_level", int'(lvl2), k);
            end
        end
        mode2 = 2'd3;
        check("tri_missing", int_q.size(), 0);
        repeat (2 * PERIOD) step();
        check("tri_frozen_level", int'(lvl2), 512);
        count_high(1'b1, 0, PERIOD, cnt);
        check("tri_duty_ch0", cnt, 128 * PRE);
        count_high(1'b1, 3, PERIOD, cnt);
        check("tri_duty_ch3", cnt, gamma_model(512) * PRE);

        // Asynchronous reset in the middle of a high PWM phase
        found = 1'b0;
        for (int i = 0; i < int'(PERIOD) && !found; i++) begin
            step();
            if (pwm[0]) found = 1'b1;
        end
        check("pre_reset_high", int'(found), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_pwm", int'(pwm), 0);
        check("async_reset_pwm2", int'(pwm2), 0);
        check("async_reset_level", int'(lvl), 0);
        check("async_reset_level2", int'(lvl2), 0);
        check("async_reset_sel", int'(sel), 0);
        check("async_reset_chg", int'(chg), 0);
        step();
        reset = 1'b0;
        mode2 = 2'd0;
        cnt = 0;
        pulses = 0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (pwm != '0) cnt++;
            if (chg) pulses++;
        end
        check("post_reset_pwm_dark", cnt, 0);
        check("post_reset_no_pulse", pulses, 0);
        for (int c = 0; c < int'(NCH); c++) begin
            check($sformatf("post_reset_ch%0d_level", int'(sel)), int'(lvl), 0);
            press_sel();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
